// File: rtl/prg_dma_loader.sv
// prg_dma_loader: copies a C64 PRG image from a byte-wide image store into
// C64 memory through DMA writes. It reads the 2-byte load address header,
// requests the bus, and writes each data byte on a phi2 high phase.
//
// Optional feature macro: PRG_LOADER_BASIC_PTR_EN
//   When defined, two more DMA writes follow the data bytes. They store the
//   end address into the BASIC pointer at $002D/$002E.
module prg_dma_loader #(
    parameter int IMAGE_AW = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                phi2,
    input  logic                BA,
    input  logic                start,
    input  logic [15:0]         image_len,
    output logic [IMAGE_AW-1:0] image_addr,
    input  logic [7:0]          image_data,
    output logic                DMA,
    output logic [15:0]         Ai,
    output logic [7:0]          Di,
    output logic                RW,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         end_addr
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        BUSREQ,
        FETCH,
        WAIT_P2H,
        WRITE,
        NEXT,
`ifdef PRG_LOADER_BASIC_PTR_EN
        PTR_LO,
        PTR_HI,
`endif
        FINISH
    } state_t;

    state_t      state;
    logic        phi2_q;
    logic        rd_phase;
    logic [15:0] len_q;
    logic [15:0] load_addr;
    logic [15:0] n;
    logic [7:0]  byte_buf;
`ifdef PRG_LOADER_BASIC_PTR_EN
    logic        ptr_wr;
`endif

    logic        phi2_rise;
    logic        phi2_fall;
    logic [15:0] n_next;
    logic        more_data;
    logic [15:0] end_calc;

    // phi2 edge detection, next-byte bookkeeping and the end address.
    // All of this arithmetic wraps modulo 2^16, as the C64 address space does.
    always_comb begin
        phi2_rise = phi2 & ~phi2_q;
        phi2_fall = ~phi2 & phi2_q;
        n_next    = n + 16'd1;
        more_data = (({1'b0, n_next} + 17'd2) < {1'b0, len_q});
        end_calc  = load_addr + len_q - 16'd2;
    end

    // Previous phi2 sample. It has no reset, because it only ever mirrors the
    // live input one clk later.
    always_ff @(posedge clk) begin
        phi2_q <= phi2;
    end

    // Main loader FSM. Each image read presents image_addr on entry to a read
    // state, and then captures image_data on the second clk of that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_phase   <= 1'b0;
            len_q      <= 16'd0;
            load_addr  <= 16'd0;
            n          <= 16'd0;
            byte_buf   <= 8'd0;
            image_addr <= '0;
            DMA        <= 1'b0;
            Ai         <= 16'd0;
            Di         <= 8'd0;
            RW         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            end_addr   <= 16'd0;
`ifdef PRG_LOADER_BASIC_PTR_EN
            ptr_wr     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        len_q <= image_len;
                        if (image_len < 16'd2) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            image_addr <= '0;
                            rd_phase   <= 1'b0;
                            state      <= HDR_LO;
                        end
                    end
                end

                HDR_LO: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        load_addr[7:0] <= image_data;
                        image_addr     <= IMAGE_AW'(16'd1);
                        rd_phase       <= 1'b0;
                        state          <= HDR_HI;
                    end
                end

                HDR_HI: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        load_addr[15:8] <= image_data;
                        rd_phase        <= 1'b0;
`ifdef PRG_LOADER_BASIC_PTR_EN
                        DMA   <= 1'b1;
                        state <= BUSREQ;
`else
                        if (len_q == 16'd2) begin
                            state <= FINISH;
                        end else begin
                            DMA   <= 1'b1;
                            state <= BUSREQ;
                        end
`endif
                    end
                end

                BUSREQ: begin
                    if (BA) begin
`ifdef PRG_LOADER_BASIC_PTR_EN
                        if (len_q == 16'd2) begin
                            ptr_wr <= 1'b0;
                            state  <= PTR_LO;
                        end else begin
                            n          <= 16'd0;
                            image_addr <= IMAGE_AW'(16'd2);
                            rd_phase   <= 1'b0;
                            state      <= FETCH;
                        end
`else
                        n          <= 16'd0;
                        image_addr <= IMAGE_AW'(16'd2);
                        rd_phase   <= 1'b0;
                        state      <= FETCH;
`endif
                    end
                end

                FETCH: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        byte_buf <= image_data;
                        rd_phase <= 1'b0;
                        state    <= WAIT_P2H;
                    end
                end

                WAIT_P2H: begin
                    if (phi2_rise && BA) begin
                        Ai    <= load_addr + n;
                        Di    <= byte_buf;
                        RW    <= 1'b0;
                        state <= WRITE;
                    end else begin
                        RW <= 1'b1;
                    end
                end

                WRITE: begin
                    if (phi2_fall) begin
                        RW    <= 1'b1;
                        state <= NEXT;
                    end
                end

                NEXT: begin
                    n <= n_next;
                    if (more_data) begin
                        image_addr <= IMAGE_AW'(n_next + 16'd2);
                        rd_phase   <= 1'b0;
                        state      <= FETCH;
                    end else begin
`ifdef PRG_LOADER_BASIC_PTR_EN
                        ptr_wr <= 1'b0;
                        state  <= PTR_LO;
`else
                        state  <= FINISH;
`endif
                    end
                end

`ifdef PRG_LOADER_BASIC_PTR_EN
                PTR_LO: begin
                    if (!ptr_wr) begin
                        if (phi2_rise && BA) begin
                            Ai     <= 16'h002D;
                            Di     <= end_calc[7:0];
                            RW     <= 1'b0;
                            ptr_wr <= 1'b1;
                        end
                    end else if (phi2_fall) begin
                        RW     <= 1'b1;
                        ptr_wr <= 1'b0;
                        state  <= PTR_HI;
                    end
                end

                PTR_HI: begin
                    if (!ptr_wr) begin
                        if (phi2_rise && BA) begin
                            Ai     <= 16'h002E;
                            Di     <= end_calc[15:8];
                            RW     <= 1'b0;
                            ptr_wr <= 1'b1;
                        end
                    end else if (phi2_fall) begin
                        RW     <= 1'b1;
                        ptr_wr <= 1'b0;
                        state  <= FINISH;
                    end
                end
`endif

                FINISH: begin
                    DMA      <= 1'b0;
                    RW       <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    end_addr <= end_calc;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/prg_dma_loader.md
PRG_DMA_LOADER -- requirements
Module: prg_dma_loader

Interface
REQ-001 Parameter IMAGE_AW, default 13: image store address width, in bits.
REQ-002 Port clk, input, 1: dot clock; sole clock domain.
REQ-003 Port reset, input, 1: synchronous, active-high.
REQ-004 Port phi2, input, 1: C64 CPU phase, synchronous to clk.
REQ-005 Port BA, input, 1: bus available from the C64; high means the bus is free.
REQ-006 Port start, input, 1: single-clk pulse that begins a load.
REQ-007 Port image_len, input, 16: total image byte count, including the 2-byte PRG header.
REQ-008 Port image_addr, output, IMAGE_AW: read address into the image store.
REQ-009 Port image_data, input, 8: image store data, valid one clk after image_addr.
REQ-010 Port DMA, output, 1: high requests the C64 bus.
REQ-011 Port Ai, output, 16: DMA write address.
REQ-012 Port Di, output, 8: DMA write data.
REQ-013 Port RW, output, 1: 1 means read/idle, 0 means write.
REQ-014 Port busy, output, 1: a load is in progress.
REQ-015 Port done, output, 1: one-clk pulse when a load completes.
REQ-016 Port err, output, 1: sticky; set when image_len < 2; cleared by the next accepted start.
REQ-017 Port end_addr, output, 16: load address plus the data byte count, as of the last completed load.

Function
REQ-018 The block SHALL implement these states: IDLE, HDR_LO, HDR_HI, BUSREQ, FETCH, WAIT_P2H, WRITE, NEXT, PTR_LO, PTR_HI, FINISH.
REQ-019 In IDLE, start SHALL be accepted only when busy=0; a start with busy=1 SHALL be ignored.
REQ-020 On an accepted start with image_len < 2, the block SHALL set err=1, pulse done, and return to IDLE without asserting DMA.
REQ-021 HDR_LO SHALL read image offset 0 into load address [7:0]; HDR_HI SHALL read offset 1 into load address [15:8].
REQ-022 Each image read SHALL take 2 clks: present image_addr, then capture image_data.
REQ-023 BUSREQ SHALL assert DMA=1 and hold DMA until FINISH.
REQ-024 The block SHALL wait in BUSREQ until BA=1.
REQ-025 FETCH SHALL read the byte at image offset 2+n into Di, where n counts data bytes from 0.
REQ-026 WAIT_P2H SHALL wait for a phi2 rising edge, detected as phi2=1 with the registered phi2=0.
REQ-027 At that phi2 rising edge with BA=1, the block SHALL drive Ai = load_addr+n, Di, and RW=0, then enter WRITE.
REQ-028 At that phi2 rising edge with BA=0, the block SHALL stay in WAIT_P2H with RW=1.
REQ-029 WRITE SHALL hold Ai, Di and RW=0 stable until a phi2 falling edge.
REQ-030 At the phi2 falling edge the block SHALL set RW=1 and enter NEXT.
REQ-031 NEXT SHALL increment n and return to FETCH while 2+n < image_len; otherwise it SHALL go to the pointer states (macro defined) or to FINISH.
REQ-032 Ai SHALL be computed modulo 2^16, so a load crossing $FFFF wraps to $0000.
REQ-033 end_addr SHALL equal (load_addr + image_len - 2) mod 2^16.
REQ-034 Image offsets SHALL be truncated to IMAGE_AW bits.
REQ-035 FINISH SHALL deassert DMA, drive RW=1, set busy=0, pulse done for 1 clk, and return to IDLE.
REQ-036 image_len=2 SHALL produce zero data writes, with end_addr = load address.
REQ-037 Ai and Di SHALL hold their last values when not writing; RW SHALL be 1 outside WRITE.

Reset
REQ-038 On reset=1 at a clk edge, the block SHALL enter IDLE and force DMA=0, RW=1, busy=0, done=0, err=0, Ai=0, Di=0, end_addr=0, image_addr=0.
REQ-039 A reset in the middle of a load SHALL abandon it: no further writes, and DMA=0 on the clk after reset is sampled.

Configuration
REQ-040 With macro PRG_LOADER_BASIC_PTR_EN defined, after the last data byte the block SHALL perform two more DMA writes, using the same phi2/BA handshake as data bytes.
REQ-041 Those writes SHALL be $002D <= end_addr[7:0] (PTR_LO), then $002E <= end_addr[15:8] (PTR_HI), then FINISH.
REQ-042 Without PRG_LOADER_BASIC_PTR_EN, PTR_LO and PTR_HI SHALL be absent and NEXT SHALL go directly to FINISH.

Verification
REQ-043 Image 01 08 A9 05 (len 4), BA=1 -> writes $0801<=A9 then $0802<=05; end_addr=$0803; one done pulse; DMA low after done.
REQ-044 Same image with BA forced low for 3 phi2 cycles before the first write -> DMA=1 throughout, no RW=0 while BA=0, then the same two writes.
REQ-045 Header FF FF plus 3 data bytes 11 22 33 -> writes $FFFF<=11, $0000<=22, $0001<=33; end_addr=$0002.
REQ-046 image_len=1 -> err=1, done pulse, DMA never asserted; a second start with len 2 and header 00 C0 -> err=0, end_addr=$C000, no writes.
REQ-047 Reset asserted after the first of 4 data writes -> DMA=0 next clk, no further RW=0, all outputs at reset values.
REQ-048 With PRG_LOADER_BASIC_PTR_EN defined, the REQ-043 image -> additional writes $002D<=03 and $002E<=08 before done; start pulsed while busy -> ignored.
